reg_access_seq: RTL

//  Sequencer between the CPU-side request port and the register array built from

---
 rtl/reg_access_seq_if.sv | 26 ++
 rtl/reg_access_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reg_access_seq_if.sv
// Request/response port of the register access sequencer.
// master = CPU side, slave = sequencer side.
interface reg_access_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/reg_access_seq.sv
// Sequencer turning one CPU read/write into the select/read/latch/strobe timing of
// read-latched register cells. Define REG_SEQ_ADDRCHK_EN to reject addr >= NREG with resp_err.
module reg_access_seq #(
  parameter int NREG  = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3   // NREG must not exceed 2**AW
) (
  input  logic             clk,
  input  logic             rst,
  reg_access_seq_if.slave  bus,
  output logic [NREG-1:0]  sel,
  output logic             rd,
  output logic             rd_latch,
  output logic             wr_strobe,
  output logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata_in
);

  typedef enum logic [3:0] {
    IDLE,
    RD_SEL,
    RD_LAT,
    RD_REL,
    RD_CAP,
    WR_SET,
    WR_STB,
    WR_HLD,
    RESP
  } state_t;

  state_t state;
  logic   addr_err;

  // Out-of-range addresses decode to an all-zero select.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++)
      if (int'(a) == i) oh[i] = 1'b1;
    return oh;
  endfunction

`ifdef REG_SEQ_ADDRCHK_EN
  assign addr_err = ~|onehot(bus.req_addr);
`else
  assign addr_err = 1'b0;
`endif

  // Every output is a flop loaded with the value for the state being entered,
  // so nothing reaches the ports combinationally from req_*.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops sampling pre-edge values,
    // independent of statement order inside this block.
    if (rst) begin
      state          <= IDLE;
      sel            <= '0;
      rd             <= 1'b0;
      rd_latch       <= 1'b0;
      wr_strobe      <= 1'b0;
      wdata          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (addr_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_wr) begin
              state <= WR_SET;
              sel   <= onehot(bus.req_addr);
              wdata <= bus.req_wdata;
            end else begin
              state <= RD_SEL;
              sel   <= onehot(bus.req_addr);
              rd    <= 1'b1;
            end
          end
        end
        RD_SEL: begin
          state    <= RD_LAT;
          rd_latch <= 1'b1;
        end
        RD_LAT: begin
          state    <= RD_REL;
          rd_latch <= 1'b0;
        end
        RD_REL: begin
          state <= RD_CAP;
          rd    <= 1'b0;
        end
        RD_CAP: begin
          state          <= RESP;
          sel            <= '0;
          bus.resp_rdata <= rdata_in;
          bus.resp_valid <= 1'b1;
        end
        WR_SET: begin
          state     <= WR_STB;
          wr_strobe <= 1'b1;
        end
        WR_STB: begin
          state          <= WR_HLD;
          wr_strobe      <= 1'b0;
          bus.resp_rdata <= '0;
        end
        WR_HLD: begin
          state          <= RESP;
          sel            <= '0;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          sel            <= '0;
          rd             <= 1'b0;
          rd_latch       <= 1'b0;
          wr_strobe      <= 1'b0;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
